out_logger: RTL and testbench
=============================

OUT_LOGGER -- requirements
Module: out_logger

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 Parameter HALT_TAG, default 1'b1, bit-8 value marking a halt record.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out_reg  input  8  CPU output-register value, sampled every clk.
REQ-006 halted  input  1  CPU halted level.
REQ-007 tx_data  output  9  head record: [8]=tag (0 value, HALT_TAG halt), [7:0]=payload.
REQ-008 tx_valid  output  1  head record valid.
REQ-009 tx_ready  input  1  downstream accepts head when tx_valid&&tx_ready at posedge.
REQ-010 overflow  output  1  sticky: at least one value record dropped.
REQ-011 drop_count  output  8  dropped value records, saturating at 255.
REQ-012 done  output  1  halt record has been pushed into FIFO.

Function
REQ-013 Block SHALL hold prev register (8 bit) and halted_q register; both update every cycle from out_reg/halted.
REQ-014 Value event SHALL occur in a cycle where out_reg != prev; record {0, out_reg}.
REQ-015 Halt event SHALL occur when halted && !halted_q; sets halt_pending.
REQ-016 At most one push per cycle; value event SHALL take priority over halt_pending in the same cycle.
REQ-017 halt_pending SHALL push {HALT_TAG, out_reg} in the first cycle with no value event and FIFO room, then clear and set done.
REQ-018 Push SHALL be accepted when count < DEPTH, or count == DEPTH and a pop occurs that cycle.
REQ-019 Value event with no room SHALL be dropped: overflow <= 1, drop_count += 1 unless 255.
REQ-020 Halt record SHALL never be dropped; it waits while FIFO full.
REQ-021 Pop SHALL occur on tx_valid && tx_ready; tx_valid == (count != 0); tx_data SHALL be the oldest entry, stable while tx_valid && !tx_ready.
REQ-022 Push into empty FIFO SHALL make tx_valid high the next cycle (one-cycle latency); no combinational in-to-out path.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-024 After done, further halt rising edges SHALL be ignored; value events SHALL still be logged.
REQ-025 Pop of empty FIFO SHALL be impossible (tx_valid low); tx_ready while empty has no effect.

Reset
REQ-026 On reset: prev=0x00, halted_q=0, halt_pending=0, pointers/count=0, tx_valid=0, tx_data=0, overflow=0, drop_count=0, done=0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and pending halt immediately (asynchronous).
REQ-028 First cycle after reset release SHALL compare out_reg against prev=0x00 (nonzero value logs).

Structure
REQ-029 Shared package sap1_pkg SHALL hold record width (9), tag bit index (8), HALT_TAG and default DEPTH.
REQ-030 FIFO SHALL be a sub-module sync_fifo (DEPTH, WIDTH, push/pop/full/empty/count); out_logger holds detection, halt sequencing, counters.

Verification
REQ-031 out_reg 0->5->5->9, tx_ready=1 -> records {0,05},{0,09} in order, one cycle after each change.
REQ-032 tx_ready=0, 10 distinct changes, DEPTH=8 -> 8 held, overflow=1, drop_count=2; then drain -> first 8 values exact.
REQ-033 out_reg change and halted rise in same cycle (value 0x2A) -> {0,2A} then {1,2A} next cycle, done high after halt push.
REQ-034 FIFO full, halted rises, tx_ready=0 for 5 cycles then 1 -> halt record pushed after first pop, never dropped, drop_count unchanged by it.
REQ-035 Reset asserted between clock edges while 4 records queued -> tx_valid, overflow, done low immediately; no old record emitted after release.
REQ-036 300 dropped events with tx_ready=0 -> drop_count saturates at 255, overflow stays 1.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the output logger and its record FIFO.
package sap1_pkg;

  // Record layout: [8] = tag, [7:0] = payload
  localparam int unsigned REC_W        = 9;
  localparam int unsigned TAG_BIT      = 8;
  localparam logic        HALT_TAG_DEF = 1'b1;
  localparam int unsigned DEPTH_DEF    = 8;

  // Halt sequencing: idle -> waiting for a push slot -> halt record queued
  typedef enum logic [1:0] {
    H_IDLE,
    H_PENDING,
    H_DONE
  } halt_state_e;

  // Assemble a record from tag bit and payload byte
  function automatic logic [REC_W-1:0] make_rec(input logic tag, input logic [7:0] payload);
    logic [REC_W-1:0] r;
    r          = '0;
    r[TAG_BIT] = tag;
    r[7:0]     = payload;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head entry is presented from registers, zero when empty.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module sync_fifo
  import sap1_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = REC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO state registers; reset discards all contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/out_logger.sv
// Logs changes of the CPU output register and a single halt marker into a
// FIFO for a ready/valid consumer. Value records are dropped (and counted)
// when the FIFO has no room; the halt record waits instead of dropping.
module out_logger
  import sap1_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic        HALT_TAG = HALT_TAG_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       out_reg,
  input  logic             halted,
  output logic [REC_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             overflow,
  output logic [7:0]       drop_count,
  output logic             done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]       prev_q, prev_d;
  logic             halted_q, halted_d;
  halt_state_e      halt_state_q, halt_state_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic             value_evt, halt_rise, pending_now;
  logic             fifo_push, fifo_pop, fifo_room;
  logic [REC_W-1:0] push_rec;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_rec),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid   = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = done_q;

  // Event detection and push arbitration: a value change wins the single push
  // slot; a pending halt (including one rising this cycle) takes the next free slot
  always_comb begin
    prev_d       = out_reg;
    halted_d     = halted;
    halt_state_d = halt_state_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    fifo_push    = 1'b0;
    push_rec     = '0;

    value_evt   = (out_reg != prev_q);
    halt_rise   = halted && !halted_q;
    pending_now = (halt_state_q == H_PENDING) ||
                  ((halt_state_q == H_IDLE) && halt_rise);
    fifo_pop    = tx_ready && !fifo_empty;
    fifo_room   = !fifo_full || fifo_pop;

    if (value_evt) begin
      if (fifo_room) begin
        fifo_push = 1'b1;
        push_rec  = make_rec(1'b0, out_reg);
      end else begin
        overflow_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
      if (pending_now) begin
        halt_state_d = H_PENDING;
      end
    end else if (pending_now) begin
      if (fifo_room) begin
        fifo_push    = 1'b1;
        push_rec     = make_rec(HALT_TAG, out_reg);
        halt_state_d = H_DONE;
        done_d       = 1'b1;
      end else begin
        halt_state_d = H_PENDING;
      end
    end
  end

  // Detection history, halt FSM and drop statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      halted_q     <= 1'b0;
      halt_state_q <= H_IDLE;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      prev_q       <= prev_d;
      halted_q     <= halted_d;
      halt_state_q <= halt_state_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Occupancy can never exceed the configured depth
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_out_logger.sv
// Directed self-checking bench for out_logger (DEPTH=8, HALT_TAG=1).
module tb_out_logger;

  logic       clk;
  logic       reset;
  logic [7:0] out_reg;
  logic       halted;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       overflow;
  logic [7:0] drop_count;
  logic       done;

  int checks   = 0;
  int failures = 0;

  out_logger #(
    .DEPTH    (8),
    .HALT_TAG (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_reg    (out_reg),
    .halted     (halted),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .drop_count (drop_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o;
    logic       h;
    logic       r;
    logic       v;
    logic [8:0] d;
    logic       dn;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] o);
    out_reg  = o;
    halted   = 1'b0;
    tx_ready = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) begin
      out_reg = 8'(i);
      step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    out_reg  = 8'h00;
    halted   = 1'b0;
    tx_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(tx_valid), 16'h0);
    chk("rst_data", 16'(tx_data), 16'h000);
    chk("rst_overflow", 16'(overflow), 16'h0);
    chk("rst_drop", 16'(drop_count), 16'h00);
    chk("rst_done", 16'(done), 16'h0);
    reset = 1'b0;

    // Table: value changes, simultaneous change+halt, ignored second halt
    tbl[0]  = '{8'h00, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[1]  = '{8'h05, 1'b0, 1'b1, 1'b1, 9'h005, 1'b0};
    tbl[2]  = '{8'h05, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[3]  = '{8'h09, 1'b0, 1'b1, 1'b1, 9'h009, 1'b0};
    tbl[4]  = '{8'h09, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[5]  = '{8'h2A, 1'b1, 1'b0, 1'b1, 9'h02A, 1'b0};
    tbl[6]  = '{8'h2A, 1'b1, 1'b0, 1'b1, 9'h02A, 1'b1};
    tbl[7]  = '{8'h2A, 1'b1, 1'b1, 1'b1, 9'h12A, 1'b1};
    tbl[8]  = '{8'h2A, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1};
    tbl[9]  = '{8'h2A, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1};
    tbl[10] = '{8'h2A, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1};
    tbl[11] = '{8'h33, 1'b1, 1'b0, 1'b1, 9'h033, 1'b1};
    tbl[12] = '{8'h33, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1};

    for (int i = 0; i < 13; i++) begin
      out_reg  = tbl[i].o;
      halted   = tbl[i].h;
      tx_ready = tbl[i].r;
      step();
      chk($sformatf("vec%0d_valid", i), 16'(tx_valid), 16'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), 16'(tx_data), 16'(tbl[i].d));
      chk($sformatf("vec%0d_done", i), 16'(done), 16'(tbl[i].dn));
      chk($sformatf("vec%0d_ovf", i), 16'(overflow), 16'h0);
    end

    // Ten changes into a depth-8 FIFO with no consumer, then drain
    do_reset(8'h00);
    fill(10);
    chk("ovf10_overflow", 16'(overflow), 16'h1);
    chk("ovf10_drop", 16'(drop_count), 16'h02);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 16'(tx_valid), 16'h1);
      chk($sformatf("drain%0d_data", k), 16'(tx_data), 16'(k));
      step();
    end
    chk("drain_end_valid", 16'(tx_valid), 16'h0);

    // Halt while full waits for the first pop and is never dropped
    do_reset(8'h00);
    fill(8);
    halted = 1'b1;
    repeat (5) step();
    chk("hfull_done_wait", 16'(done), 16'h0);
    chk("hfull_drop_wait", 16'(drop_count), 16'h00);
    chk("hfull_ovf_wait", 16'(overflow), 16'h0);
    chk("hfull_head_wait", 16'(tx_data), 16'h001);
    tx_ready = 1'b1;
    step();
    chk("hfull_done", 16'(done), 16'h1);
    chk("hfull_head2", 16'(tx_data), 16'h002);
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("hdrain%0d_data", k), 16'(tx_data), 16'(k));
      step();
    end
    chk("hfull_halt_valid", 16'(tx_valid), 16'h1);
    chk("hfull_halt_rec", 16'(tx_data), 16'h108);
    step();
    chk("hfull_empty", 16'(tx_valid), 16'h0);
    chk("hfull_drop_final", 16'(drop_count), 16'h00);

    // Asynchronous reset between edges with four records queued
    do_reset(8'h00);
    fill(3);
    halted = 1'b1;
    step();
    chk("arst_pre_done", 16'(done), 16'h1);
    chk("arst_pre_valid", 16'(tx_valid), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 16'(tx_valid), 16'h0);
    chk("arst_done", 16'(done), 16'h0);
    chk("arst_overflow", 16'(overflow), 16'h0);
    chk("arst_data", 16'(tx_data), 16'h000);
    out_reg  = 8'h00;
    halted   = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_post%0d_valid", k), 16'(tx_valid), 16'h0);
    end

    // First cycle after release compares against a zero history
    do_reset(8'h77);
    step();
    chk("first_valid", 16'(tx_valid), 16'h1);
    chk("first_data", 16'(tx_data), 16'h077);

    // Drop counter saturation
    do_reset(8'h00);
    fill(8);
    for (int i = 0; i < 300; i++) begin
      out_reg = (i % 2 == 0) ? 8'h55 : 8'hAA;
      step();
      if (i == 253) chk("sat_drop254", 16'(drop_count), 16'h00FE);
    end
    chk("sat_drop", 16'(drop_count), 16'h00FF);
    chk("sat_overflow", 16'(overflow), 16'h1);
    chk("sat_head", 16'(tx_data), 16'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
